// File: rtl/cont_mem_pkg.sv
// Shared types and arithmetic helpers for the continuous class-HV memory.
package cont_mem_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACCUM
  } state_t;

  // Signed add clamped to the range of a w-bit two's complement counter.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] s;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    s  = a + b;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

  // Sign of the counter decides the bit; a zero counter follows the training bit.
  function automatic logic binarise(input logic signed [31:0] cnt, input logic tiebit);
    if (cnt > 0) begin
      return 1'b1;
    end else if (cnt < 0) begin
      return 1'b0;
    end
    return tiebit;
  endfunction

endpackage

// File: rtl/cont_mem_lane.sv
// One dimension's counter update and re-binarisation, purely combinational.
// With CONT_MEM_DECAY_EN defined the old count is decayed by DECAY_SHIFT first.
module cont_mem_lane
  import cont_mem_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef CONT_MEM_DECAY_EN
  , parameter int unsigned DECAY_SHIFT = 4
`endif
) (
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             hv_bit,
  output logic [CNT_W-1:0] cnt_out,
  output logic             bit_out
);

  logic signed [31:0] cur;
  logic signed [31:0] base;
  logic signed [31:0] delta;
  logic signed [31:0] nxt;

  // Sign-extend, optionally decay, add +/-1 with saturation, then binarise.
  always_comb begin
    cur = 32'(signed'(cnt_in));
`ifdef CONT_MEM_DECAY_EN
    base = cur - (cur >>> DECAY_SHIFT);
`else
    base = cur;
`endif
    delta   = hv_bit ? 32'sd1 : -32'sd1;
    nxt     = sat_add(base, delta, CNT_W);
    cnt_out = nxt[CNT_W-1:0];
    bit_out = binarise(nxt, hv_bit);
  end

endmodule

// File: rtl/cont_mem_acc_hf.sv
// Continuous class-HV memory: per-dimension saturating counters per class, updated
// CHUNK dimensions per cycle from a labelled training HV.
// Optional macro CONT_MEM_DECAY_EN adds DECAY_SHIFT exponential forgetting.
module cont_mem_acc_hf
  import cont_mem_pkg::*;
#(
  parameter int unsigned DIMENSIONS  = 10000,
  parameter int unsigned NUM_CLASSES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned CHUNK       = 1000,
  parameter logic [NUM_CLASSES*DIMENSIONS-1:0] START_HVS =
      {{DIMENSIONS{1'b1}}, {DIMENSIONS{1'b0}}},
`ifdef CONT_MEM_DECAY_EN
  parameter int unsigned DECAY_SHIFT = 4,
`endif
  parameter int unsigned CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [CLASS_W-1:0]                label,
  input  logic [DIMENSIONS-1:0]             hv,
  input  logic                              clr,
  output logic                              ready,
  output logic                              done,
  output logic                              err,
  output logic [NUM_CLASSES*DIMENSIONS-1:0] class_hvs
);

  localparam int unsigned NCHUNK  = (DIMENSIONS + CHUNK - 1) / CHUNK;
  localparam int unsigned CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned DIM_W   = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

  state_t               state_q, state_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic [DIMENSIONS-1:0] hv_q;
  logic [CLASS_W-1:0]   label_q;
  logic [CNT_W-1:0]     cnt_q   [NUM_CLASSES][DIMENSIONS];
  logic [DIMENSIONS-1:0] class_q [NUM_CLASSES];
  logic                 done_q, err_q;

  logic load_start, accept, bad_label, done_d, last_chunk;

  logic [31:0]      lane_dim     [CHUNK];
  logic             lane_valid   [CHUNK];
  logic [DIM_W-1:0] lane_idx     [CHUNK];
  logic [CNT_W-1:0] lane_cnt_in  [CHUNK];
  logic [CNT_W-1:0] lane_cnt_out [CHUNK];
  logic             lane_hv      [CHUNK];
  logic             lane_bit     [CHUNK];

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    load_start = 1'b0;
    accept     = 1'b0;
    bad_label  = 1'b0;
    done_d     = 1'b0;
    last_chunk = (chunk_q == CHUNK_W'(NCHUNK - 1));
    case (state_q)
      IDLE: begin
        if (clr) begin
          load_start = 1'b1;
        end else if (en) begin
          if (32'(label) >= NUM_CLASSES) begin
            bad_label = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ACCUM;
            chunk_d = '0;
          end
        end
      end
      ACCUM: begin
        if (last_chunk) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          chunk_d = chunk_q + CHUNK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and chunk counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
    end
  end

  // Route the current chunk's counters and HV bits to the lanes; lanes past the end idle.
  always_comb begin
    for (int unsigned j = 0; j < CHUNK; j++) begin
      lane_dim[j]    = 32'(chunk_q) * CHUNK + 32'(j);
      lane_valid[j]  = (lane_dim[j] < DIMENSIONS);
      lane_idx[j]    = lane_valid[j] ? lane_dim[j][DIM_W-1:0] : '0;
      lane_cnt_in[j] = cnt_q[label_q][lane_idx[j]];
      lane_hv[j]     = hv_q[lane_idx[j]];
    end
  end

  for (genvar j = 0; j < CHUNK; j++) begin : g_lane
    cont_mem_lane #(
      .CNT_W(CNT_W)
`ifdef CONT_MEM_DECAY_EN
      , .DECAY_SHIFT(DECAY_SHIFT)
`endif
    ) u_lane (
      .cnt_in (lane_cnt_in[j]),
      .hv_bit (lane_hv[j]),
      .cnt_out(lane_cnt_out[j]),
      .bit_out(lane_bit[j])
    );
  end

  // Storage: reload on reset/clr, latch the request on accept, write back one chunk per cycle.
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        class_q[k] <= START_HVS[k*DIMENSIONS +: DIMENSIONS];
        for (int unsigned d = 0; d < DIMENSIONS; d++) begin
          cnt_q[k][d] <= START_HVS[k*DIMENSIONS + d] ? CNT_W'(1) : {CNT_W{1'b1}};
        end
      end
      hv_q    <= '0;
      label_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= bad_label;
      if (accept) begin
        hv_q    <= hv;
        label_q <= label;
      end
      if (state_q == ACCUM) begin
        for (int unsigned j = 0; j < CHUNK; j++) begin
          if (lane_valid[j]) begin
            cnt_q[label_q][lane_idx[j]]   <= lane_cnt_out[j];
            class_q[label_q][lane_idx[j]] <= lane_bit[j];
          end
        end
      end
    end
  end

  // Flatten the class memories onto the output bus.
  always_comb begin
    class_hvs = '0;
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      class_hvs[k*DIMENSIONS +: DIMENSIONS] = class_q[k];
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cont_mem_acc_hf.sv
// Bench for cont_mem_acc_hf: a 16-dim/2-class instance and a 10-dim/3-class
// instance (partial last chunk, out-of-range label) against a counter model.
module tb_cont_mem_acc_hf;

  localparam logic [29:0] START_B = {10'h155, 10'h3FF, 10'h000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_clr, a_label;
  logic [15:0] a_hv;
  logic        a_ready, a_done, a_err;
  logic [31:0] a_class_hvs;
  logic        b_en, b_clr;
  logic [1:0]  b_label;
  logic [9:0]  b_hv;
  logic        b_ready, b_done, b_err;
  logic [29:0] b_class_hvs;

  int   checks = 0;
  int   errors = 0;
  int   mc [2][3][16];
  logic mb [2][3][16];

  cont_mem_acc_hf #(
    .DIMENSIONS (16),
    .NUM_CLASSES(2),
    .CNT_W      (4),
    .CHUNK      (4)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (a_en),
    .label    (a_label),
    .hv       (a_hv),
    .clr      (a_clr),
    .ready    (a_ready),
    .done     (a_done),
    .err      (a_err),
    .class_hvs(a_class_hvs)
  );

  cont_mem_acc_hf #(
    .DIMENSIONS (10),
    .NUM_CLASSES(3),
    .CNT_W      (4),
    .CHUNK      (4),
    .START_HVS  (START_B)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (b_en),
    .label    (b_label),
    .hv       (b_hv),
    .clr      (b_clr),
    .ready    (b_ready),
    .done     (b_done),
    .err      (b_err),
    .class_hvs(b_class_hvs)
  );

  function automatic int ndims(input int w);
    return (w != 0) ? 10 : 16;
  endfunction

  function automatic int ncls(input int w);
    return (w != 0) ? 3 : 2;
  endfunction

  function automatic logic rdy(input int w);
    return (w != 0) ? b_ready : a_ready;
  endfunction

  function automatic logic dn(input int w);
    return (w != 0) ? b_done : a_done;
  endfunction

  function automatic logic er(input int w);
    return (w != 0) ? b_err : a_err;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic e, input logic c, input int lbl,
                       input logic [15:0] h);
    if (w != 0) begin
      b_en = e; b_clr = c; b_label = 2'(lbl); b_hv = h[9:0];
    end else begin
      a_en = e; a_clr = c; a_label = 1'(lbl); a_hv = h;
    end
  endtask

  task automatic model_reset(input int w);
    logic [29:0] sb;
    sb = START_B;
    for (int k = 0; k < ncls(w); k++) begin
      for (int d = 0; d < ndims(w); d++) begin
        mb[w][k][d] = (w != 0) ? sb[k*10 + d] : (k == 1);
        mc[w][k][d] = mb[w][k][d] ? 1 : -1;
      end
    end
  endtask

  task automatic model_update(input int w, input int lbl, input logic [15:0] h);
    for (int d = 0; d < ndims(w); d++) begin
      int c;
      c = mc[w][lbl][d];
`ifdef CONT_MEM_DECAY_EN
      c = c - (c >>> 4);
`endif
      c = c + (h[d] ? 1 : -1);
      if (c > 7) c = 7;
      if (c < -8) c = -8;
      mc[w][lbl][d] = c;
      mb[w][lbl][d] = (c > 0) ? 1'b1 : (c < 0) ? 1'b0 : h[d];
    end
  endtask

  task automatic check_classes(input int w, input string tag);
    for (int k = 0; k < ncls(w); k++) begin
      logic [15:0] e;
      logic [15:0] o;
      e = '0;
      for (int d = 0; d < ndims(w); d++) e[d] = mb[w][k][d];
      o = (w != 0) ? 16'(b_class_hvs[k*10 +: 10]) : a_class_hvs[k*16 +: 16];
      chk($sformatf("%s_w%0d_k%0d", tag, w, k), 32'(o), 32'(e));
    end
  endtask

  // Full update: accept, scribble on inputs while busy, check latency and result.
  task automatic upd(input int w, input int lbl, input logic [15:0] h);
    int n;
    drive(w, 1'b1, 1'b0, lbl, h);
    tick();
    drive(w, 1'b0, 1'b0, int'($urandom_range(0, 3)), 16'($urandom));
    chk("acc_ready", 32'(rdy(w)), 32'd0);
    chk("acc_done", 32'(dn(w)), 32'd0);
    model_update(w, lbl, h);
    n = 0;
    while (n < 20) begin
      drive(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 16'($urandom));
      tick();
      n++;
      if (dn(w)) break;
    end
    drive(w, 1'b0, 1'b0, 0, 16'h0);
    chk("latency", 32'(n), (w != 0) ? 32'd3 : 32'd4);
    chk("done_ready", 32'(rdy(w)), 32'd1);
    chk("busy_err", 32'(er(w)), 32'd0);
    check_classes(w, "upd");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 16'h0);
    drive(1, 1'b0, 1'b0, 0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    model_reset(0);
    model_reset(1);

    chk("rst_hvs_a", a_class_hvs, 32'hFFFF_0000);
    chk("rst_ready_a", 32'(a_ready), 32'd1);
    chk("rst_done_a", 32'(a_done), 32'd0);
    chk("rst_err_a", 32'(a_err), 32'd0);
    chk("rst_hvs_b", 32'(b_class_hvs), 32'(START_B));
    chk("rst_ready_b", 32'(b_ready), 32'd1);

    // Counters -1 -> 0 tie on class0, bits follow hv.
    upd(0, 0, 16'hFFFF);
    chk("t1_c0", 32'(a_class_hvs[15:0]), 32'h0000_FFFF);
    chk("t1_c1", 32'(a_class_hvs[31:16]), 32'h0000_FFFF);

    // Drive class1 into positive saturation and back down to zero.
    repeat (10) upd(0, 1, 16'hFFFF);
    repeat (7) upd(0, 1, 16'h0000);

    // clr wins over en in IDLE.
    drive(0, 1'b1, 1'b1, 1, 16'h1234);
    tick();
    drive(0, 1'b0, 1'b0, 0, 16'h0);
    model_reset(0);
    chk("clr_ready", 32'(a_ready), 32'd1);
    chk("clr_raw", a_class_hvs, 32'hFFFF_0000);
    check_classes(0, "clr");
    tick();
    chk("clr_done", 32'(a_done), 32'd0);

    // Reset in the middle of an update restores everything.
    drive(0, 1'b1, 1'b0, 0, 16'hFFFF);
    tick();
    drive(0, 1'b0, 1'b0, 0, 16'h0);
    tick();
    tick();
    chk("mid_ready", 32'(a_ready), 32'd0);
    chk("mid_partial", a_class_hvs, 32'hFFFF_00FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    chk("mrst_ready", 32'(a_ready), 32'd1);
    chk("mrst_done", 32'(a_done), 32'd0);
    chk("mrst_hvs", a_class_hvs, 32'hFFFF_0000);
    tick();
    chk("mrst_done2", 32'(a_done), 32'd0);

    repeat (24) upd(0, int'($urandom_range(0, 1)), 16'($urandom));

    // Out-of-range label: err pulse, no state change.
    drive(1, 1'b1, 1'b0, 3, 16'h02AA);
    tick();
    drive(1, 1'b0, 1'b0, 0, 16'h0);
    chk("err_pulse", 32'(b_err), 32'd1);
    chk("err_ready", 32'(b_ready), 32'd1);
    tick();
    chk("err_clear", 32'(b_err), 32'd0);
    chk("err_ready2", 32'(b_ready), 32'd1);
    chk("err_done", 32'(b_done), 32'd0);
    check_classes(1, "err");

    // Partial last chunk on the 10-dim instance.
    repeat (12) upd(1, int'($urandom_range(0, 2)), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
